// File: rtl/addr_sequencer_if.sv
// rtl/addr_sequencer_if.sv - handshake and address bus bundle for addr_sequencer
// Signals:
//   start, size           run request and last index (driven by the controller)
//   in_valid, out_ready   per-cycle sample/accept qualifiers for LOAD / PROC
//   addr_wr, addr_rd      write / read address sequences into the 2x1 mux
//   sel                   mux select (0 = addr_wr, 1 = addr_rd)
//   wr_en, rd_en          memory write / read strobes
//   busy, done            run status
// Modports: master drives the requests, slave is the sequencer.
interface addr_sequencer_if #(
    parameter int AW = 6
);
    logic          start;
    logic [AW-1:0] size;
    logic          in_valid;
    logic          out_ready;
    logic [AW-1:0] addr_wr;
    logic [AW-1:0] addr_rd;
    logic          sel;
    logic          wr_en;
    logic          rd_en;
    logic          busy;
    logic          done;

    modport master (
        output start, size, in_valid, out_ready,
        input  addr_wr, addr_rd, sel, wr_en, rd_en, busy, done
    );

    modport slave (
        input  start, size, in_valid, out_ready,
        output addr_wr, addr_rd, sel, wr_en, rd_en, busy, done
    );
endinterface

// File: rtl/addr_sequencer.sv
// rtl/addr_sequencer.sv - LOAD/PROC address sequencer driving the 6-bit address mux
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   bus   slave modport of addr_sequencer_if (start/size/in_valid/out_ready in;
//         addr_wr/addr_rd/sel/wr_en/rd_en/busy/done out)
// One accepted start runs a LOAD pass writing indices 0..size, then a PROC pass
// reading indices 0..size, then a single DONE cycle back to IDLE.
module addr_sequencer #(
    parameter int AW = 6
) (
    input  logic              clk,
    input  logic              rst,
    addr_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PROC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q;
    logic [AW-1:0] size_q;
    logic [AW-1:0] addr_wr_q;
    logic [AW-1:0] addr_rd_q;
    logic          sel_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            size_q    <= '0;
            addr_wr_q <= '0;
            addr_rd_q <= '0;
            sel_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        size_q    <= bus.size;
                        addr_wr_q <= '0;
                        sel_q     <= 1'b0;
                        state_q   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // The terminal compare is taken before the increment, so a
                    // full-range size never wraps the counter back to zero.
                    if (bus.in_valid) begin
                        if (addr_wr_q == size_q) begin
                            addr_rd_q <= '0;
                            sel_q     <= 1'b1;
                            state_q   <= S_PROC;
                        end else begin
                            addr_wr_q <= addr_wr_q + AW'(1);
                        end
                    end
                end
                S_PROC: begin
                    if (bus.out_ready) begin
                        if (addr_rd_q == size_q) begin
                            state_q <= S_DONE;
                        end else begin
                            addr_rd_q <= addr_rd_q + AW'(1);
                        end
                    end
                end
                S_DONE: begin
                    // Counters and sel keep their final values until the next start.
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.addr_wr = addr_wr_q;
    assign bus.addr_rd = addr_rd_q;
    assign bus.sel     = sel_q;
    assign bus.wr_en   = (state_q == S_LOAD) && bus.in_valid;
    assign bus.rd_en   = (state_q == S_PROC) && bus.out_ready;
    assign bus.busy    = (state_q == S_LOAD) || (state_q == S_PROC);
    assign bus.done    = (state_q == S_DONE);

endmodule

// File: tb/tb_addr_sequencer.sv
// tb/tb_addr_sequencer.sv - scoreboard bench for addr_sequencer
module tb_addr_sequencer;

    localparam int AW = 6;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;
    bit   exp_busy;

    int   wr_q[$];
    int   rd_q[$];
    int   done_q[$];

    addr_sequencer_if #(.AW(AW)) bus ();

    addr_sequencer #(.AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, time %0t, required finish before 500us", $time);
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event seen with nothing expected (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops expectations whenever the DUT presents a strobe or done.
    // Timestamps are the index of the rising edge at which the value is sampled.
    always @(negedge clk) begin
        int e;
        if (!rst) begin
            if (bus.wr_en) begin
                if (wr_q.size() == 0) unexpected("wr_en");
                else begin
                    e = wr_q.pop_front();
                    check("wr_addr", int'(bus.addr_wr), e);
                    check("wr_sel", int'(bus.sel), 0);
                end
            end
            if (bus.rd_en) begin
                if (rd_q.size() == 0) unexpected("rd_en");
                else begin
                    e = rd_q.pop_front();
                    check("rd_addr", int'(bus.addr_rd), e);
                    check("rd_sel", int'(bus.sel), 1);
                end
            end
            if (bus.done) begin
                if (done_q.size() == 0) unexpected("done");
                else begin
                    e = done_q.pop_front();
                    check("done_cycle", cyc + 1, e);
                end
            end
            check("busy", int'(bus.busy), int'(exp_busy));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a run is size+1 accepted writes (addresses 0..size) then
    // size+1 accepted reads, each phase lasting until enough qualifier-high
    // cycles have been offered, followed by one done cycle.
    // mode 0: no stalls, 1: random stalls, 2: in_valid low on 2nd LOAD cycle and
    // out_ready low on 1st PROC cycle. noise toggles start/size during the run.
    task automatic run(input int sz, input int mode, input bit noise);
        int  written;
        int  readn;
        int  lcyc;
        int  pcyc;
        int  start_edge;
        bit  v;
        bus.start  = 1'b1;
        bus.size   = AW'(sz);
        start_edge = cyc + 1;
        exp_busy   = 1'b0;
        tick();
        bus.start = 1'b0;
        exp_busy  = 1'b1;
        written   = 0;
        lcyc      = 0;
        while (written <= sz) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = ($urandom_range(0, 2) != 0);
                default: v = (lcyc != 1);
            endcase
            bus.in_valid  = v;
            bus.out_ready = 1'($urandom_range(0, 1));
            if (noise) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.size  = AW'($urandom_range(0, 63));
            end
            if (v) begin
                wr_q.push_back(written);
                written++;
            end
            lcyc++;
            tick();
        end
        readn = 0;
        pcyc  = 0;
        while (readn <= sz) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = ($urandom_range(0, 2) != 0);
                default: v = (pcyc != 0);
            endcase
            bus.out_ready = v;
            bus.in_valid  = 1'($urandom_range(0, 1));
            if (noise) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.size  = AW'($urandom_range(0, 63));
            end
            if (v) begin
                rd_q.push_back(readn);
                readn++;
            end
            pcyc++;
            tick();
        end
        exp_busy = 1'b0;
        done_q.push_back(start_edge + 1 + lcyc + pcyc);
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.out_ready = 1'($urandom_range(0, 1));
        if (noise) bus.start = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("wr_drained", wr_q.size(), 0);
        check("rd_drained", rd_q.size(), 0);
        check("done_drained", done_q.size(), 0);
    endtask

    initial begin
        cyc           = 0;
        n_checks      = 0;
        n_fail        = 0;
        exp_busy      = 1'b0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.size      = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("rst_addr_wr", int'(bus.addr_wr), 0);
        check("rst_addr_rd", int'(bus.addr_rd), 0);
        check("rst_sel", int'(bus.sel), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Abort mid-LOAD once addr_wr has reached 3.
        bus.start = 1'b1;
        bus.size  = AW'(5);
        tick();
        bus.start = 1'b0;
        exp_busy  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            wr_q.push_back(i);
            tick();
        end
        bus.in_valid = 1'b0;
        check("abort_pre_addr_wr", int'(bus.addr_wr), 3);
        bus.in_valid = 1'b1;
        rst = 1'b1;
        #1;
        check("abort_addr_wr", int'(bus.addr_wr), 0);
        check("abort_wr_en", int'(bus.wr_en), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_sel", int'(bus.sel), 0);
        check("abort_done", int'(bus.done), 0);
        tick();
        bus.in_valid = 1'b0;
        exp_busy     = 1'b0;
        rst          = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("abort_wr_drained", wr_q.size(), 0);

        run(3, 0, 1'b0);
        run(2, 2, 1'b0);
        run(0, 0, 1'b0);
        run(63, 0, 1'b0);
        check("full_addr_wr_hold", int'(bus.addr_wr), 63);
        check("full_addr_rd_hold", int'(bus.addr_rd), 63);
        check("full_sel_hold", int'(bus.sel), 1);
        run(4, 0, 1'b1);
        run(7, 1, 1'b1);
        for (int r = 0; r < 12; r++) begin
            run(($urandom_range(0, 7) == 0) ? 63 : int'($urandom_range(0, 20)),
                int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        run(0, 1, 1'b1);
        for (int i = 0; i < 3; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
